// File: rtl/mux_ru_data.sv
// rtl/mux_ru_data.sv - RV32I write-back data selector with optional registered copy (MUX_RU_DATA_REG_OUT_EN)
module mux_ru_data #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] PCInc,
  input  logic [WIDTH-1:0] ALURes,
  input  logic [WIDTH-1:0] DataRd,
  input  logic [1:0]       RUDataWrSrc,
  input  logic             RUWr,
  output logic [WIDTH-1:0] DataWr,
  output logic [WIDTH-1:0] DataWrQ,
  output logic             RUWrQ,
  output logic             SelErr
);

  logic [WIDTH-1:0] w_data_sel;
  logic             w_sel_illegal;

  // Source select; an X/Z select falls through to default so it yields zero
  always_comb begin
    w_data_sel = '0;
    case (RUDataWrSrc)
      2'b00:   w_data_sel = ALURes;
      2'b01:   w_data_sel = DataRd;
      2'b10:   w_data_sel = PCInc;
      2'b11:   w_data_sel = '0;
      default: w_data_sel = '0;
    endcase
  end

  assign DataWr        = w_data_sel;
  assign w_sel_illegal = (RUDataWrSrc == 2'b11) & RUWr;

`ifdef MUX_RU_DATA_REG_OUT_EN
  logic [WIDTH-1:0] r_data_q;
  logic             r_ruwr_q;
  logic             r_sel_err;

  // One-cycle copy of the write-back data and write enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q <= '0;
      r_ruwr_q <= 1'b0;
    end else begin
      r_data_q <= w_data_sel;
      r_ruwr_q <= RUWr;
    end
  end

  // Sticky flag: an enabled write with the reserved select stays visible until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else if (w_sel_illegal) begin
      r_sel_err <= 1'b1;
    end
  end

  assign DataWrQ = r_data_q;
  assign RUWrQ   = r_ruwr_q;
  assign SelErr  = r_sel_err;
`else
  // Clock and reset have no consumer in the pass-through build
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst_n};

  assign DataWrQ = w_data_sel;
  assign RUWrQ   = RUWr;
  assign SelErr  = w_sel_illegal;
`endif

endmodule

// File: tb/tb_mux_ru_data.sv
// tb/tb_mux_ru_data.sv - randomized model-checked bench for mux_ru_data
module tb_mux_ru_data;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] PCInc = '0;
  logic [W-1:0] ALURes = '0;
  logic [W-1:0] DataRd = '0;
  logic [1:0]   RUDataWrSrc = 2'b00;
  logic         RUWr = 1'b0;
  logic [W-1:0] DataWr;
  logic [W-1:0] DataWrQ;
  logic         RUWrQ;
  logic         SelErr;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model state: what the last capturing edge saw, and how many illegal writes since reset
  logic [W-1:0] m_cap_data = '0;
  logic         m_cap_wr = 1'b0;
  int           m_illegal_cnt = 0;

  mux_ru_data #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .PCInc(PCInc), .ALURes(ALURes), .DataRd(DataRd),
    .RUDataWrSrc(RUDataWrSrc), .RUWr(RUWr), .DataWr(DataWr), .DataWrQ(DataWrQ),
    .RUWrQ(RUWrQ), .SelErr(SelErr)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] pc,
                                        input logic [W-1:0] alu, input logic [W-1:0] rd);
    logic [W-1:0] tbl [4];
    tbl[0] = alu; tbl[1] = rd; tbl[2] = pc; tbl[3] = '0;
    return tbl[s];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference history, updated at each edge the DUT would capture on
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cap_data    = '0;
      m_cap_wr      = 1'b0;
      m_illegal_cnt = 0;
    end else begin
      m_cap_data = pick(RUDataWrSrc, PCInc, ALURes, DataRd);
      m_cap_wr   = RUWr;
      if (RUDataWrSrc == 2'd3 && RUWr) m_illegal_cnt = m_illegal_cnt + 1;
    end
  end

  // Per-cycle compare away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("DataWr", DataWr, pick(RUDataWrSrc, PCInc, ALURes, DataRd));
`ifdef MUX_RU_DATA_REG_OUT_EN
      check("DataWrQ", DataWrQ, m_cap_data);
      check("RUWrQ", W'(RUWrQ), W'(m_cap_wr));
      check("SelErr", W'(SelErr), W'(m_illegal_cnt != 0));
`else
      check("DataWrQ", DataWrQ, pick(RUDataWrSrc, PCInc, ALURes, DataRd));
      check("RUWrQ", W'(RUWrQ), W'(RUWr));
      check("SelErr", W'(SelErr), W'(RUDataWrSrc == 2'd3 && RUWr));
`endif
    end
  end

  initial begin
    PCInc  = 32'h0000_0010;
    ALURes = 32'hDEAD_BEEF;
    DataRd = 32'hCAFE_BABE;
    RUDataWrSrc = 2'b00;
    RUWr = 1'b0;
    #1;
    check("sel00_comb", DataWr, 32'hDEAD_BEEF);
`ifdef MUX_RU_DATA_REG_OUT_EN
    check("rst_DataWrQ", DataWrQ, 32'h0);
`else
    check("rst_DataWrQ", DataWrQ, 32'hDEAD_BEEF);
`endif
    check("rst_RUWrQ", W'(RUWrQ), 32'h0);
    check("rst_SelErr", W'(SelErr), 32'h0);
    RUDataWrSrc = 2'b01; #1;
    check("sel01_comb", DataWr, 32'hCAFE_BABE);
    RUDataWrSrc = 2'b10; #1;
    check("sel10_comb", DataWr, 32'h0000_0010);

    #10 rst_n = 1'b1;            // released between edges
    RUDataWrSrc = 2'b11; RUWr = 1'b0;
    @(posedge clk); #1;
    check("sel11_zero", DataWr, 32'h0);
    check("sel11_nowr_err", W'(SelErr), 32'h0);
    RUWr = 1'b1;
    @(posedge clk); #1;
    check("sel11_wr_err", W'(SelErr), 32'h1);
    RUDataWrSrc = 2'b00;
    @(posedge clk); #1;
`ifdef MUX_RU_DATA_REG_OUT_EN
    check("err_sticky", W'(SelErr), 32'h1);
`else
    check("err_comb_clear", W'(SelErr), 32'h0);
`endif

    RUDataWrSrc = 2'b01; RUWr = 1'b1;
    @(posedge clk); #1;
    check("cap_DataWrQ", DataWrQ, 32'hCAFE_BABE);
    check("cap_RUWrQ", W'(RUWrQ), 32'h1);
    RUDataWrSrc = 2'b10; #1;
`ifdef MUX_RU_DATA_REG_OUT_EN
    check("hold_DataWrQ", DataWrQ, 32'hCAFE_BABE);
`else
    check("pass_DataWrQ", DataWrQ, 32'h0000_0010);
`endif

    rst_n = 1'b0; #1;            // mid-cycle reset
`ifdef MUX_RU_DATA_REG_OUT_EN
    check("arst_DataWrQ", DataWrQ, 32'h0);
    check("arst_RUWrQ", W'(RUWrQ), 32'h0);
`else
    check("arst_DataWrQ", DataWrQ, 32'h0000_0010);
    check("arst_RUWrQ", W'(RUWrQ), 32'h1);
`endif
    check("arst_SelErr", W'(SelErr), 32'h0);
    check("arst_DataWr", DataWr, 32'h0000_0010);
    RUDataWrSrc = 2'b00; #1;
    check("arst_DataWr_track", DataWr, 32'hDEAD_BEEF);
`ifndef MUX_RU_DATA_REG_OUT_EN
    check("pass_sel00", DataWrQ, 32'hDEAD_BEEF);
    check("pass_ruwr", W'(RUWrQ), 32'h1);
`endif

    @(posedge clk); #2;
    rst_n = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      PCInc  = $urandom;
      ALURes = $urandom;
      DataRd = $urandom;
      RUDataWrSrc = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      RUWr = 1'($urandom);
      if ($urandom_range(0, 49) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      @(posedge clk); #2;
    end
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
